// File: rtl/arbitro_mux_4a1.sv
// arbitro_mux_4a1: round-robin 4:1 arbiter/sequencer with valid/ready output; define ARB_LIMITE_RAFAGA_EN to cap beats per grant at MAX_RAFAGA
module arbitro_mux_4a1 #(
  parameter int DATA_W     = 32,
  parameter int MAX_RAFAGA = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] dato_0,
  input  logic [DATA_W-1:0] dato_1,
  input  logic [DATA_W-1:0] dato_2,
  input  logic [DATA_W-1:0] dato_3,
  output logic [3:0]        ack,
  input  logic              sal_ready,
  output logic              sal_valid,
  output logic [DATA_W-1:0] sal_dato,
  output logic [1:0]        control,
  output logic              ocupado
);
  localparam logic [7:0] LIM = 8'(MAX_RAFAGA - 1);
  typedef enum logic {LIBRE, CONCEDIDO} estado_t;
  estado_t est_q, est_d;
  logic [1:0] control_q, control_d, ptr_q, ptr_d, sel;
  logic [7:0] cnt_q, cnt_d;
  logic hs, corte, liberar;
  assign control   = control_q;
  assign ocupado   = est_q == CONCEDIDO;
  assign sal_valid = ocupado & req[control_q];
  assign hs        = sal_valid & sal_ready;
  assign ack       = hs ? 4'b0001 << control_q : 4'b0000;
  assign liberar   = (hs & last[control_q]) | ~req[control_q] | corte;
`ifdef ARB_LIMITE_RAFAGA_EN
  assign corte = hs & ~last[control_q] & (cnt_q == LIM);
`else
  logic unused_lim;
  assign unused_lim = ^LIM;
  assign corte = 1'b0;
`endif
  // output word follows the registered select, also while idle
  always_comb begin
    sal_dato = control_q[1] ? (control_q[0] ? dato_3 : dato_2) : (control_q[0] ? dato_1 : dato_0);
  end
  // round-robin search: lowest offset after the last served requester wins
  always_comb begin
    sel = ptr_q;
    for (int k = 4; k >= 1; k--) sel = req[ptr_q + 2'(k)] ? ptr_q + 2'(k) : sel;
  end
  // next state: grant from LIBRE, count beats and release from CONCEDIDO
  always_comb begin
    est_d     = est_q;
    control_d = control_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (est_q == LIBRE) begin
      if (|req) begin
        est_d     = CONCEDIDO;
        control_d = sel;
        cnt_d     = 8'd0;
      end
    end else begin
      cnt_d = (hs && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
      if (liberar) begin
        est_d = LIBRE;
        ptr_d = control_q;
      end
    end
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q     <= LIBRE;
      control_q <= 2'b00;
      ptr_q     <= 2'b11;
      cnt_q     <= 8'd0;
    end else begin
      est_q     <= est_d;
      control_q <= control_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_arbitro_mux_4a1.sv
// tb_arbitro_mux_4a1: directed self-checking bench for the round-robin arbiter
module tb_arbitro_mux_4a1;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req, last, ack;
  logic [31:0] dato_0, dato_1, dato_2, dato_3, sal_dato;
  logic sal_ready, sal_valid, ocupado;
  logic [1:0] control;
  int checks = 0;
  int failures = 0;

  arbitro_mux_4a1 #(.DATA_W(32), .MAX_RAFAGA(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .dato_0(dato_0), .dato_1(dato_1), .dato_2(dato_2), .dato_3(dato_3),
    .ack(ack), .sal_ready(sal_ready), .sal_valid(sal_valid),
    .sal_dato(sal_dato), .control(control), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    last = 4'b0000;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    last = 4'b0000;
    sal_ready = 1'b1;
    dato_0 = 32'hA0A0_0000;
    dato_1 = 32'hA1A1_1111;
    dato_2 = 32'hA2A2_2222;
    dato_3 = 32'hA3A3_3333;
    #2;
    checks++; if (control !== 2'd0) begin failures++; $display("FAIL reset_control got=%0d exp=0", control); end
    checks++; if (sal_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", sal_valid); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
    checks++; if (sal_dato !== 32'hA0A0_0000) begin failures++; $display("FAIL reset_dato got=%h exp=a0a00000", sal_dato); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0100;
    last = 4'b0100;
    dato_2 = 32'hCAFE_0002;
    sal_ready = 1'b1;
    #1;
    checks++; if (sal_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", sal_valid); end
    @(negedge clk);
    #1;
    checks++; if (control !== 2'd2) begin failures++; $display("FAIL single_control got=%0d exp=2", control); end
    checks++; if (sal_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", sal_valid); end
    checks++; if (sal_dato !== 32'hCAFE_0002) begin failures++; $display("FAIL single_dato got=%h exp=cafe0002", sal_dato); end
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ack); end
    req = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL single_release got=%b exp=0", ocupado); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    pulse_reset();
    req = 4'b1111;
    last = 4'b1111;
    sal_ready = 1'b1;
    foreach (order[n]) begin
      @(negedge clk);
      #1;
      checks++; if (control !== 2'(order[n])) begin failures++; $display("FAIL rr_control[%0d] got=%0d exp=%0d", n, control, order[n]); end
      checks++; if (ack !== 4'b0001 << order[n]) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", n, ack, 4'b0001 << order[n]); end
      @(negedge clk);
      #1;
      checks++; if (ocupado !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL rr_bubble[%0d] got ocupado=%b ack=%b exp ocupado=0 ack=0000", n, ocupado, ack); end
    end
    req = 4'b0000;
  endtask

  task automatic test_burst_stall();
    logic rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int beat = 0;
    int acks = 0;
    @(negedge clk);
    req = 4'b0010;
    last = 4'b0000;
    dato_1 = 32'hB000_0000;
    foreach (rdy[k]) begin
      @(negedge clk);
      sal_ready = rdy[k];
      dato_1 = 32'hB000_0000 + 32'(beat);
      last = (beat == 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (control !== 2'd1 || sal_valid !== 1'b1) begin failures++; $display("FAIL burst_grant[%0d] got control=%0d valid=%b exp control=1 valid=1", k, control, sal_valid); end
      checks++; if (sal_dato !== 32'hB000_0000 + 32'(beat)) begin failures++; $display("FAIL burst_dato[%0d] got=%h exp=%h", k, sal_dato, 32'hB000_0000 + 32'(beat)); end
      checks++; if (ack !== (rdy[k] ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL burst_ack[%0d] got=%b exp=%b", k, ack, rdy[k] ? 4'b0010 : 4'b0000); end
      if (ack[1]) acks++;
      if (rdy[k]) beat++;
    end
    @(negedge clk);
    req = 4'b0000;
    last = 4'b0000;
    sal_ready = 1'b1;
    #1;
    checks++; if (acks != 3) begin failures++; $display("FAIL burst_ack_count got=%0d exp=3", acks); end
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL burst_release got=%b exp=0", ocupado); end
  endtask

  task automatic test_abandon();
    @(negedge clk);
    req = 4'b1001;
    last = 4'b0000;
    sal_ready = 1'b1;
    dato_3 = 32'hD000_0003;
    @(negedge clk);
    #1;
    checks++; if (control !== 2'd3 || ack !== 4'b1000) begin failures++; $display("FAIL abandon_grant got control=%0d ack=%b exp control=3 ack=1000", control, ack); end
    req = 4'b0101;
    #1;
    checks++; if (sal_valid !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL abandon_drop got valid=%b ack=%b exp valid=0 ack=0000", sal_valid, ack); end
    @(negedge clk);
    #1;
    checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL abandon_release got=%b exp=0", ocupado); end
    @(negedge clk);
    #1;
    checks++; if (control !== 2'd0 || ack !== 4'b0001) begin failures++; $display("FAIL abandon_next got control=%0d ack=%b exp control=0 ack=0001", control, ack); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    req = 4'b0100;
    last = 4'b0000;
    sal_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (control !== 2'd2 || ack !== 4'b0100) begin failures++; $display("FAIL midrst_grant got control=%0d ack=%b exp control=2 ack=0100", control, ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (control !== 2'd0 || sal_valid !== 1'b0 || ack !== 4'b0000 || ocupado !== 1'b0) begin failures++; $display("FAIL midrst_values got control=%0d valid=%b ack=%b ocupado=%b exp 0/0/0000/0", control, sal_valid, ack, ocupado); end
    req = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (control !== 2'd0 || ack !== 4'b0001) begin failures++; $display("FAIL midrst_first got control=%0d ack=%b exp control=0 ack=0001", control, ack); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rafaga();
`ifdef ARB_LIMITE_RAFAGA_EN
    int seq [16] = '{-1, 0, 1, 2, 3, -1, 10, -1, 4, 5, 6, 7, -1, 8, 9, -1};
`else
    int seq [14] = '{-1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 10, -1};
`endif
    int nb0 = 0;
    logic served1 = 1'b0;
    pulse_reset();
    sal_ready = 1'b1;
    dato_1 = 32'h1111_0001;
    foreach (seq[n]) begin
      if (n != 0) @(negedge clk);
      req = {2'b00, ~served1, nb0 < 10};
      last = {2'b00, 1'b1, nb0 == 9};
      dato_0 = 32'h0000_1000 + 32'(nb0);
      #1;
      if (seq[n] < 0) begin
        checks++; if (ocupado !== 1'b0 || sal_valid !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL rafaga_bubble[%0d] got ocupado=%b valid=%b ack=%b exp 0/0/0000", n, ocupado, sal_valid, ack); end
      end else if (seq[n] == 10) begin
        checks++; if (control !== 2'd1 || ack !== 4'b0010 || sal_dato !== 32'h1111_0001) begin failures++; $display("FAIL rafaga_req1[%0d] got control=%0d ack=%b dato=%h exp 1/0010/11110001", n, control, ack, sal_dato); end
      end else begin
        checks++; if (control !== 2'd0 || ack !== 4'b0001 || sal_dato !== 32'h0000_1000 + 32'(seq[n])) begin failures++; $display("FAIL rafaga_req0[%0d] got control=%0d ack=%b dato=%h exp 0/0001/%h", n, control, ack, sal_dato, 32'h0000_1000 + 32'(seq[n])); end
      end
      if (ack[0]) nb0++;
      if (ack[1]) served1 = 1'b1;
    end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_stall();
    test_abandon();
    test_mid_reset();
    test_rafaga();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
